// File: rtl/hdlc_protocol_monitor.sv
// ---------------------------------------------------------------------------
// HdlcProtocolMonitor
//   Watches CH independent HDLC bit streams alongside the status outputs of
//   the HDLC engine under observation and flags protocol violations in four
//   classes: missed flag detect, missed abort detect, missing zero insertion
//   inside a frame, and line held low while idle.
//
// Ports
//   Clk          sole clock, rising edge
//   Rst          asynchronous active-high reset
//   En           global check enable
//   CheckEn[3:0] per-class enable: [0] flag, [1] abort, [2] zero-ins, [3] idle
//   Clear        synchronous clear of counters and sticky bits
//   Line         serial bit per channel
//   ValidFrame   engine status per channel: inside a frame body
//   FlagDetect   engine status per channel: flag seen
//   AbortDetect  engine status per channel: abort seen
//   ErrPulse     one-cycle pulse per channel with any error
//   ErrCode      per-channel nibble of failing classes, 0 when no pulse
//   ErrCnt       per-channel saturating error count, channel c at [c*CNT_W +: CNT_W]
//   ErrTotal     saturating sum of error pulses across channels
//   Sticky       per-class OR of all errors since reset/Clear
// ---------------------------------------------------------------------------
module hdlc_protocol_monitor #(
  parameter int CH       = 2,
  parameter int CNT_W    = 16,
  parameter int FLAG_LAT = 2,
  parameter int IDLE_LEN = 8
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic [3:0]            CheckEn,
  input  logic                  Clear,
  input  logic [CH-1:0]         Line,
  input  logic [CH-1:0]         ValidFrame,
  input  logic [CH-1:0]         FlagDetect,
  input  logic [CH-1:0]         AbortDetect,
  output logic [CH-1:0]         ErrPulse,
  output logic [4*CH-1:0]       ErrCode,
  output logic [CH*CNT_W-1:0]   ErrCnt,
  output logic [CNT_W-1:0]      ErrTotal,
  output logic [3:0]            Sticky
);

  localparam int               IDLE_W  = $clog2(IDLE_LEN + 1);
  localparam int               SUM_W   = CNT_W + 4;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [7:0]       FLAG_PAT  = 8'h7E;
  localparam logic [7:0]       ABORT_PAT = 8'h7F;

  logic [7:0]          hist_q      [CH];
  logic [7:0]          hist_d      [CH];
  logic [FLAG_LAT-1:0] flagPipe_q  [CH];
  logic [FLAG_LAT-1:0] flagPipe_d  [CH];
  logic [FLAG_LAT-1:0] abortPipe_q [CH];
  logic [FLAG_LAT-1:0] abortPipe_d [CH];
  logic [2:0]          ones_q      [CH];
  logic [2:0]          ones_d      [CH];
  logic [IDLE_W-1:0]   idle_q      [CH];
  logic [IDLE_W-1:0]   idle_d      [CH];
  logic [3:0]          code_q      [CH];
  logic [3:0]          code_d      [CH];
  logic [CNT_W-1:0]    cnt_q       [CH];
  logic [CNT_W-1:0]    cnt_d       [CH];
  logic [CH-1:0]       pulse_q, pulse_d;
  logic [CNT_W-1:0]    total_q, total_d;
  logic [3:0]          sticky_q, sticky_d;
  logic [3:0]          anyCode;
  logic [3:0]          classGate;
  logic [SUM_W-1:0]    sum;

  // Next-state and error evaluation for every channel. The history includes
  // the current Line bit so a pattern matches in the cycle its last bit
  // arrives; matches ride a FLAG_LAT-deep pipeline and are judged against the
  // engine's detect outputs when they fall out of its far end.
  always_comb begin
    pulse_d   = '0;
    anyCode   = '0;
    classGate = CheckEn & {4{En}};
    sum       = SUM_W'(total_q);
    for (int c = 0; c < CH; c++) begin
      hist_d[c]      = {hist_q[c][6:0], Line[c]};
      flagPipe_d[c]  = FLAG_LAT'({flagPipe_q[c], hist_d[c] == FLAG_PAT});
      abortPipe_d[c] = FLAG_LAT'({abortPipe_q[c], hist_d[c] == ABORT_PAT});

      if (ValidFrame[c] && Line[c]) begin
        ones_d[c] = (ones_q[c] == 3'd6) ? 3'd6 : ones_q[c] + 3'd1;
      end else begin
        ones_d[c] = 3'd0;
      end

      if (ValidFrame[c]) begin
        idle_d[c] = '0;
      end else begin
        idle_d[c] = (idle_q[c] == IDLE_W'(IDLE_LEN)) ? idle_q[c] : idle_q[c] + IDLE_W'(1);
      end

      code_d[c] = classGate & {
        (idle_q[c] == IDLE_W'(IDLE_LEN)) && !Line[c],
        (ones_q[c] == 3'd5) && Line[c] && ValidFrame[c],
        abortPipe_q[c][FLAG_LAT-1] && !AbortDetect[c],
        flagPipe_q[c][FLAG_LAT-1] && !FlagDetect[c]
      };
      pulse_d[c] = |code_d[c];
      anyCode    = anyCode | code_d[c];

      if (Clear) begin
        cnt_d[c] = '0;
      end else if (pulse_d[c] && (cnt_q[c] != CNT_MAX)) begin
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
      end else begin
        cnt_d[c] = cnt_q[c];
      end

      sum = sum + SUM_W'(pulse_d[c]);
    end

    // The sum is formed wide so a saturated total plus several channels
    // cannot wrap before the clamp.
    if (Clear) begin
      total_d  = '0;
      sticky_d = '0;
    end else begin
      total_d  = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : sum[CNT_W-1:0];
      sticky_d = sticky_q | anyCode;
    end
  end

  // History resets to all ones so no pattern can be assembled from bits seen
  // before reset; clearing the pipelines drops any pending expectation.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int c = 0; c < CH; c++) begin
        hist_q[c]      <= 8'hFF;
        flagPipe_q[c]  <= '0;
        abortPipe_q[c] <= '0;
        ones_q[c]      <= '0;
        idle_q[c]      <= '0;
        code_q[c]      <= '0;
        cnt_q[c]       <= '0;
      end
      pulse_q  <= '0;
      total_q  <= '0;
      sticky_q <= '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        hist_q[c]      <= hist_d[c];
        flagPipe_q[c]  <= flagPipe_d[c];
        abortPipe_q[c] <= abortPipe_d[c];
        ones_q[c]      <= ones_d[c];
        idle_q[c]      <= idle_d[c];
        code_q[c]      <= code_d[c];
        cnt_q[c]       <= cnt_d[c];
      end
      pulse_q  <= pulse_d;
      total_q  <= total_d;
      sticky_q <= sticky_d;
    end
  end

  for (genvar g = 0; g < CH; g++) begin : gPack
    assign ErrCode[g*4 +: 4]       = code_q[g];
    assign ErrCnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

  assign ErrPulse = pulse_q;
  assign ErrTotal = total_q;
  assign Sticky   = sticky_q;

endmodule

// File: doc/hdlc_protocol_monitor.md
HDLC_PROTOCOL_MONITOR -- requirements
Module: hdlc_protocol_monitor

Interface
REQ-001 SHALL have parameter CH, 2, number of independent HDLC bit-stream channels monitored (1..8).
REQ-002 SHALL have parameter CNT_W, 16, width of every error counter.
REQ-003 SHALL have parameter FLAG_LAT, 2, required cycles from the last pattern bit to the FlagDetect/AbortDetect response (1..4).
REQ-004 SHALL have parameter IDLE_LEN, 8, consecutive ValidFrame-low cycles before the idle check arms.
REQ-005 SHALL have port Clk  in  1  sole clock; all state updates on rising edge.
REQ-006 SHALL have port Rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port En  in  1  global check enable.
REQ-008 SHALL have port CheckEn  in  4  per-class enable: [0] flag, [1] abort, [2] zero-insertion, [3] idle.
REQ-009 SHALL have port Clear  in  1  synchronous clear of counters and sticky bits.
REQ-010 SHALL have port Line  in  CH  serial HDLC bit per channel, one bit per cycle.
REQ-011 SHALL have port ValidFrame, FlagDetect, AbortDetect  in  CH each  DUT status per channel.
REQ-012 SHALL have port ErrPulse  out  CH  one-cycle pulse per channel with any error.
REQ-013 SHALL have port ErrCode  out  4*CH  per-channel nibble of failing classes (bit order as CheckEn), valid with ErrPulse, else 0.
REQ-014 SHALL have port ErrCnt  out  CH*CNT_W  per-channel saturating error count; channel c at [c*CNT_W +: CNT_W].
REQ-015 SHALL have port ErrTotal  out  CNT_W  saturating sum across channels.
REQ-016 SHALL have port Sticky  out  4  per-class OR of all errors since reset/Clear.

Function
REQ-017 Each channel SHALL keep an 8-bit history of Line, newest bit shifting in every cycle regardless of En/CheckEn.
REQ-018 Flag match at cycle t SHALL be history == 0111_1110 (oldest first, including Line at t); flag error SHALL be flagged at t+FLAG_LAT if FlagDetect is 0 then.
REQ-019 Abort match at t SHALL be history == 0111_1111; abort error at t+FLAG_LAT if AbortDetect is 0 then.
REQ-020 Pending flag/abort expectations SHALL be held in a FLAG_LAT-deep per-channel pipeline; overlapping matches SHALL each be checked independently.
REQ-021 Zero-insertion: a ones-run counter (saturating at 6) SHALL count consecutive Line=1 while ValidFrame=1, reset on Line=0 or ValidFrame=0; error when counter is 5 and Line=1 with ValidFrame=1.
REQ-022 ValidFrame is defined low during opening/closing flags and aborts; the zero-insertion check SHALL rely on that contract.
REQ-023 Idle: an idle counter SHALL count ValidFrame-low cycles, saturating at IDLE_LEN, reset on ValidFrame=1; error each cycle counter==IDLE_LEN and Line=0.
REQ-024 A class SHALL raise an error only if En=1 and its CheckEn bit is 1 in the cycle the check is evaluated (t+FLAG_LAT for flag/abort, t otherwise).
REQ-025 ErrPulse/ErrCode SHALL be registered: asserted the cycle after the violating evaluation cycle.
REQ-026 ErrCnt[c] SHALL increment by 1 on the edge that asserts ErrPulse[c], once per cycle regardless of how many classes fail.
REQ-027 ErrTotal SHALL increment by the number of channels with ErrPulse asserting that edge.
REQ-028 All counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 Clear SHALL take priority: counters and Sticky go to 0 and that cycle's errors are not counted nor recorded in Sticky; ErrPulse/ErrCode still assert.
REQ-030 Channels SHALL be fully independent; no error on one channel SHALL affect another's state.

Reset
REQ-031 On Rst high, asynchronously: histories to 8'hFF, expectation pipelines, ones-run and idle counters to 0, ErrPulse, ErrCode, ErrCnt, ErrTotal, Sticky to 0.
REQ-032 Reset mid-frame SHALL discard all pending expectations; no error SHALL be reported for patterns that straddle reset deassertion.

Verification
REQ-033 Line ch0 = 0,1,1,1,1,1,1,0 at t0..t7, FlagDetect high at t9 -> no ErrPulse; repeat with FlagDetect low at t9 -> ErrPulse[0] at t10, ErrCode[3:0]=0001, ErrCnt[0]=1, Sticky=0001.
REQ-034 Line ch1 = 0 then seven 1s, AbortDetect never high -> ErrPulse[1] two cycles after...+1 (t=last bit+3), ErrCode[7:4]=0010, ErrTotal=1.
REQ-035 ValidFrame=1, Line six consecutive 1s -> one zero-insertion error, ErrCode=0100; with CheckEn[2]=0 -> no error.
REQ-036 ValidFrame low 8 cycles then Line=0 for 3 cycles -> 3 idle errors, ErrCnt[0]=3; same on both channels same cycles -> ErrTotal=6.
REQ-037 CNT_W=4, 20 forced errors on ch0 -> ErrCnt[0]=15 holds; Clear coincident with an error -> ErrCnt=0, ErrPulse still 1, Sticky=0.
REQ-038 Rst asserted between flag bit 7 and t+FLAG_LAT -> all outputs 0, no error after release.
